// File: rtl/tagged_predictor_assoc.sv
// tagged_predictor_assoc: N-way set-associative tagged TAGE component.
// A set is indexed by folded history ^ PC. All ways' tags are compared in parallel.
// The table reports the hit entry and an allocation candidate.
// After reset the table clears its own storage one set per cycle.
// Optional feature macro: TAGGED_USEFUL_DECAY_EN. It adds periodic useful-bit aging.
module tagged_predictor_assoc #(
  parameter int INPUT_GHR_LENGTH = 4,
  parameter int PHT_DEPTH        = 1024,
  parameter int PHT_WAYS         = 2,
  parameter int PHT_TAG_WIDTH    = 11,
  parameter int PHT_CTR_WIDTH    = 3,
  parameter int PHT_USEFUL_WIDTH = 2,
  parameter int DECAY_PERIOD     = 262144,
  parameter int ADDR_WIDTH       = 32,
  localparam int SET_W = $clog2(PHT_DEPTH),
  localparam int WAY_W = (PHT_WAYS > 1) ? $clog2(PHT_WAYS) : 1,
  localparam int GHR_W = INPUT_GHR_LENGTH + 1,
  localparam int TAG_W = PHT_TAG_WIDTH,
  localparam int CTR_W = PHT_CTR_WIDTH,
  localparam int U_W   = PHT_USEFUL_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              global_history_update_i,
  input  logic [GHR_W-1:0]  global_history_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  output logic              ready_o,
  output logic              taken_o,
  output logic              tag_hit_o,
  output logic [WAY_W-1:0]  hit_way_o,
  output logic [CTR_W-1:0]  ctr_bits_o,
  output logic [U_W-1:0]    useful_bits_o,
  output logic [TAG_W-1:0]  query_tag_o,
  output logic [SET_W-1:0]  hit_index_o,
  output logic              alloc_valid_o,
  output logic [WAY_W-1:0]  alloc_way_o,
  input  logic              update_valid_i,
  input  logic [SET_W-1:0]  update_index_i,
  input  logic [WAY_W-1:0]  update_way_i,
  input  logic [TAG_W-1:0]  update_tag_i,
  input  logic [CTR_W-1:0]  update_ctr_i,
  input  logic [U_W-1:0]    update_useful_i,
  input  logic              update_ctr,
  input  logic              inc_ctr,
  input  logic              update_useful,
  input  logic              inc_useful,
  input  logic              realloc_entry,
  output logic              update_drop_o
);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [CTR_W-1:0] ctr;
    logic [U_W-1:0]   useful;
  } entry_t;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1
`ifdef TAGGED_USEFUL_DECAY_EN
    , ST_DECAY = 2'd2
`endif
  } state_t;

  localparam logic [SET_W:0]   LAST_SET    = (SET_W+1)'(PHT_DEPTH - 1);
  localparam logic [CTR_W-1:0] CTR_MAX     = '1;
  localparam logic [U_W-1:0]   U_MAX       = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);

  // Fold a history slice into 'width' bits by XOR-ing bit i into position i mod width.
  function automatic logic [31:0] csr_hash(input logic [GHR_W-1:0] hist, input int width);
    logic [31:0] folded;
    folded = '0;
    for (int o = 0; o < 32; o++) begin
      for (int i = 0; i < GHR_W; i++) begin
        if ((o < width) && ((i % width) == o)) folded[o] = folded[o] ^ hist[i];
      end
    end
    return folded;
  endfunction

  entry_t pht_mem [PHT_WAYS][PHT_DEPTH];
  entry_t rd_d [PHT_WAYS];
  entry_t rd_q [PHT_WAYS];
  entry_t upd_entry;

  state_t             state_q, state_d;
  logic [SET_W:0]     sweep_q, sweep_d;
  logic [SET_W-1:0]   csr_idx_q, csr_idx_d;
  logic [TAG_W-1:0]   csr1_q, csr1_d;
  logic [TAG_W-2:0]   csr2_q, csr2_d;
  logic [SET_W-1:0]   qidx_q, qidx_d;
  logic [TAG_W-1:0]   qtag_q, qtag_d;
  logic               qvalid_q, qvalid_d;
  logic [SET_W-1:0]   q_index;
  logic [TAG_W-1:0]   q_tag;
  logic [SET_W-1:0]   rd_set;
  logic               run, init_we, upd_we;
  logic               unused_pc;

`ifdef TAGGED_USEFUL_DECAY_EN
  logic [31:0]        decay_cnt_q, decay_cnt_d;
  logic               decay_we;
  logic [SET_W-1:0]   decay_set;
  entry_t             decay_entry [PHT_WAYS];
`endif

  assign unused_pc = ^pc_i;

  // State register for the FSM, sweep counter and aging counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
`ifdef TAGGED_USEFUL_DECAY_EN
      decay_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
`ifdef TAGGED_USEFUL_DECAY_EN
      decay_cnt_q <= decay_cnt_d;
`endif
    end
  end

  // Next-state logic: clear sweep, run, and (optionally) aging sweep.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
`ifdef TAGGED_USEFUL_DECAY_EN
    decay_cnt_d = decay_cnt_q;
`endif
    case (state_q)
      ST_INIT: begin
        if (sweep_q == LAST_SET) begin
          state_d = ST_RUN;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      ST_RUN: begin
`ifdef TAGGED_USEFUL_DECAY_EN
        if (decay_cnt_q == 32'(DECAY_PERIOD - 1)) begin
          state_d     = ST_DECAY;
          decay_cnt_d = '0;
          sweep_d     = '0;
        end else begin
          decay_cnt_d = decay_cnt_q + 32'd1;
        end
`endif
      end
`ifdef TAGGED_USEFUL_DECAY_EN
      ST_DECAY: begin
        // The read of set k and the write of set k-1 overlap, so the sweep runs one extra cycle.
        if (sweep_q == (SET_W+1)'(PHT_DEPTH)) begin
          state_d = ST_RUN;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  // FSM outputs: readiness, write enables and the dropped-update pulse.
  always_comb begin
    run           = (state_q == ST_RUN);
    ready_o       = run;
    init_we       = (state_q == ST_INIT);
    upd_we        = update_valid_i & run;
    update_drop_o = update_valid_i & ~run & rst_n;
`ifdef TAGGED_USEFUL_DECAY_EN
    decay_we      = (state_q == ST_DECAY) && (sweep_q != '0);
`endif
  end

  // Entry written by an update: saturating adjust, pass-through, or fresh allocation.
  always_comb begin
    upd_entry.tag    = update_tag_i;
    upd_entry.ctr    = update_ctr_i;
    upd_entry.useful = update_useful_i;
    if (realloc_entry) begin
      upd_entry.ctr    = inc_ctr ? CTR_WEAK_T : CTR_WEAK_NT;
      upd_entry.useful = '0;
    end else begin
      if (update_ctr) begin
        if (inc_ctr) begin
          if (update_ctr_i != CTR_MAX) upd_entry.ctr = update_ctr_i + 1'b1;
        end else if (update_ctr_i != '0) begin
          upd_entry.ctr = update_ctr_i - 1'b1;
        end
      end
      if (update_useful) begin
        if (inc_useful) begin
          if (update_useful_i != U_MAX) upd_entry.useful = update_useful_i + 1'b1;
        end else if (update_useful_i != '0) begin
          upd_entry.useful = update_useful_i - 1'b1;
        end
      end
    end
  end

  // Query hashing, folded-history refresh and the read set / bypass selection.
  always_comb begin
    q_index  = pc_i[SET_W-1:0] ^ pc_i[2*SET_W-1:SET_W] ^ csr_idx_q;
    q_tag    = pc_i[2 +: TAG_W] ^ csr1_q ^ {csr2_q, 1'b0};
    csr_idx_d = csr_idx_q;
    csr1_d    = csr1_q;
    csr2_d    = csr2_q;
    if (global_history_update_i) begin
      csr_idx_d = SET_W'(csr_hash(global_history_i, SET_W));
      csr1_d    = TAG_W'(csr_hash(global_history_i, TAG_W));
      csr2_d    = (TAG_W-1)'(csr_hash(global_history_i, TAG_W - 1));
    end
    qidx_d   = q_index;
    qtag_d   = q_tag;
    qvalid_d = run;
    rd_set   = q_index;
`ifdef TAGGED_USEFUL_DECAY_EN
    if (state_q == ST_DECAY) rd_set = sweep_q[SET_W-1:0];
    decay_set = SET_W'(sweep_q - 1'b1);
`endif
    for (int w = 0; w < PHT_WAYS; w++) begin
      rd_d[w] = pht_mem[w][rd_set];
      if (upd_we && (update_way_i == WAY_W'(w)) && (update_index_i == rd_set)) rd_d[w] = upd_entry;
`ifdef TAGGED_USEFUL_DECAY_EN
      decay_entry[w]        = rd_q[w];
      decay_entry[w].useful = rd_q[w].useful >> 1;
`endif
    end
  end

  // History folds and the delayed query tag/index/valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_idx_q <= '0;
      csr1_q    <= '0;
      csr2_q    <= '0;
      qidx_q    <= '0;
      qtag_q    <= '0;
      qvalid_q  <= 1'b0;
    end else begin
      csr_idx_q <= csr_idx_d;
      csr1_q    <= csr1_d;
      csr2_q    <= csr2_d;
      qidx_q    <= qidx_d;
      qtag_q    <= qtag_d;
      qvalid_q  <= qvalid_d;
    end
  end

  // Table storage: one write source per state, plus the synchronous read of all ways.
  always_ff @(posedge clk) begin
    for (int w = 0; w < PHT_WAYS; w++) begin
      if (init_we) begin
        pht_mem[w][sweep_q[SET_W-1:0]] <= '0;
      end
`ifdef TAGGED_USEFUL_DECAY_EN
      else if (decay_we) begin
        pht_mem[w][decay_set] <= decay_entry[w];
      end
`endif
      else if (upd_we && (update_way_i == WAY_W'(w))) begin
        pht_mem[w][update_index_i] <= upd_entry;
      end
      rd_q[w] <= rd_d[w];
    end
  end

  // Hit and allocation selection: the lowest-numbered qualifying way wins.
  always_comb begin
    logic             hit;
    logic [WAY_W-1:0] hway;
    logic [CTR_W-1:0] hctr;
    logic [U_W-1:0]   huse;
    logic             aval;
    logic [WAY_W-1:0] away;
    hit  = 1'b0;
    hway = '0;
    hctr = '0;
    huse = '0;
    aval = 1'b0;
    away = '0;
    if (qvalid_q) begin
      for (int w = PHT_WAYS - 1; w >= 0; w--) begin
        if (rd_q[w].tag == qtag_q) begin
          hit  = 1'b1;
          hway = WAY_W'(w);
          hctr = rd_q[w].ctr;
          huse = rd_q[w].useful;
        end
        if (rd_q[w].useful == '0) begin
          aval = 1'b1;
          away = WAY_W'(w);
        end
      end
    end
    tag_hit_o     = hit;
    hit_way_o     = hway;
    ctr_bits_o    = hctr;
    useful_bits_o = huse;
    taken_o       = hit & hctr[CTR_W-1];
    alloc_valid_o = aval;
    alloc_way_o   = away;
    query_tag_o   = qtag_q;
    hit_index_o   = qidx_q;
  end

endmodule

// File: tb/tb_tagged_predictor_assoc.sv
// Testbench for tagged_predictor_assoc: directed checks followed by a random run.
// The random run is compared against a per-entry table model.
`timescale 1ns/1ps
module tb_tagged_predictor_assoc;
  localparam int DEPTH = 1024;
  localparam int WAYS  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ghu;
  logic [4:0]  ghr;
  logic [31:0] pc;
  logic        ready, taken, hit, aval, drop;
  logic [0:0]  hway, away;
  logic [2:0]  ctr;
  logic [1:0]  useful_b;
  logic [10:0] qtag;
  logic [9:0]  qidx;
  logic        uvalid;
  logic [9:0]  uidx;
  logic [0:0]  uway;
  logic [10:0] utag;
  logic [2:0]  uctr;
  logic [1:0]  uuse;
  logic        u_ctr, i_ctr, u_use, i_use, realloc;

  int total = 0;
  int bad = 0;

  int unsigned m_tag [WAYS][DEPTH];
  int unsigned m_ctr [WAYS][DEPTH];
  int unsigned m_use [WAYS][DEPTH];
  int unsigned m_ghr;
  int unsigned e_hit, e_way, e_ctr, e_use, e_taken, e_av, e_aw, e_qtag, e_qidx;

  always #5 clk = ~clk;

  tagged_predictor_assoc dut (
    .clk(clk), .rst_n(rst_n),
    .global_history_update_i(ghu), .global_history_i(ghr), .pc_i(pc),
    .ready_o(ready), .taken_o(taken), .tag_hit_o(hit), .hit_way_o(hway),
    .ctr_bits_o(ctr), .useful_bits_o(useful_b), .query_tag_o(qtag), .hit_index_o(qidx),
    .alloc_valid_o(aval), .alloc_way_o(away),
    .update_valid_i(uvalid), .update_index_i(uidx), .update_way_i(uway), .update_tag_i(utag),
    .update_ctr_i(uctr), .update_useful_i(uuse), .update_ctr(u_ctr), .inc_ctr(i_ctr),
    .update_useful(u_use), .inc_useful(i_use), .realloc_entry(realloc), .update_drop_o(drop)
  );

`ifdef TAGGED_USEFUL_DECAY_EN
  logic        d_rst_n, d_uvalid, d_ready, d_taken, d_hit, d_aval, d_drop;
  logic [31:0] d_pc;
  logic [2:0]  d_uidx, d_ctr, d_qidx;
  logic [0:0]  d_uway, d_hway, d_away;
  logic [10:0] d_utag, d_qtag;
  logic [1:0]  d_uuse, d_useful;

  tagged_predictor_assoc #(.PHT_DEPTH(8), .DECAY_PERIOD(16)) dut_decay (
    .clk(clk), .rst_n(d_rst_n),
    .global_history_update_i(1'b0), .global_history_i(5'd0), .pc_i(d_pc),
    .ready_o(d_ready), .taken_o(d_taken), .tag_hit_o(d_hit), .hit_way_o(d_hway),
    .ctr_bits_o(d_ctr), .useful_bits_o(d_useful), .query_tag_o(d_qtag), .hit_index_o(d_qidx),
    .alloc_valid_o(d_aval), .alloc_way_o(d_away),
    .update_valid_i(d_uvalid), .update_index_i(d_uidx), .update_way_i(d_uway), .update_tag_i(d_utag),
    .update_ctr_i(3'd0), .update_useful_i(d_uuse), .update_ctr(1'b0), .inc_ctr(1'b0),
    .update_useful(1'b0), .inc_useful(1'b0), .realloc_entry(1'b0), .update_drop_o(d_drop)
  );
`endif

  // Fold a value into w-bit chunks combined with XOR.
  function automatic int unsigned fold(input int unsigned value, input int w);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = value;
    while (v != 0) begin
      r = r ^ (v % (32'd1 << w));
      v = v >> w;
    end
    return r;
  endfunction

  function automatic int unsigned idx_of(input int unsigned p, input int unsigned g, input int sw);
    int unsigned m;
    m = (32'd1 << sw) - 1;
    return (p & m) ^ ((p >> sw) & m) ^ fold(g, sw);
  endfunction

  function automatic int unsigned tag_of(input int unsigned p, input int unsigned g);
    return (((p >> 2) & 32'h7FF) ^ fold(g, 11) ^ (fold(g, 10) << 1)) & 32'h7FF;
  endfunction

  function automatic int unsigned sat(input int unsigned v, input bit inc, input int unsigned mx);
    if (inc) return (v >= mx) ? mx : v + 1;
    return (v == 0) ? 0 : v - 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Drive one cycle (optional update, query, history refresh) and advance the model.
  task automatic applyStimulus(input bit upd, input int unsigned ui, input int unsigned uw,
                               input int unsigned ut, input int unsigned uci, input int unsigned uui,
                               input bit uc, input bit ic, input bit uu, input bit iu, input bit re,
                               input int unsigned qpc, input bit gu, input int unsigned gv);
    int unsigned qi;
    pc = qpc; ghu = gu; ghr = 5'(gv);
    uvalid = upd; uidx = 10'(ui); uway = 1'(uw); utag = 11'(ut);
    uctr = 3'(uci); uuse = 2'(uui);
    u_ctr = uc; i_ctr = ic; u_use = uu; i_use = iu; realloc = re;
    qi = idx_of(qpc, m_ghr, 10);
    e_qidx = qi;
    e_qtag = tag_of(qpc, m_ghr);
    if (upd) begin
      m_tag[uw][ui] = ut;
      if (re) begin
        m_ctr[uw][ui] = ic ? 4 : 3;
        m_use[uw][ui] = 0;
      end else begin
        m_ctr[uw][ui] = uc ? sat(uci, ic, 7) : uci;
        m_use[uw][ui] = uu ? sat(uui, iu, 3) : uui;
      end
    end
    e_hit = 0; e_way = 0; e_ctr = 0; e_use = 0; e_av = 0; e_aw = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (e_hit == 0 && m_tag[w][qi] == e_qtag) begin
        e_hit = 1; e_way = w; e_ctr = m_ctr[w][qi]; e_use = m_use[w][qi];
      end
      if (e_av == 0 && m_use[w][qi] == 0) begin
        e_av = 1; e_aw = w;
      end
    end
    e_taken = (e_hit == 1 && e_ctr >= 4) ? 1 : 0;
    if (gu) m_ghr = gv & 32'h1F;
    #1;
    if (upd) checkOutput("drop_run", drop, 0);
    @(posedge clk); #1;
    uvalid = 1'b0; ghu = 1'b0;
  endtask

  task automatic check_query();
    checkOutput("tag_hit", hit, e_hit);
    checkOutput("hit_way", hway, e_way);
    checkOutput("ctr", ctr, e_ctr);
    checkOutput("useful", useful_b, e_use);
    checkOutput("taken", taken, e_taken);
    checkOutput("alloc_valid", aval, e_av);
    checkOutput("alloc_way", away, e_aw);
    checkOutput("query_tag", qtag, e_qtag);
    checkOutput("hit_index", qidx, e_qidx);
  endtask

  initial begin
    int n;
    int unsigned pool [8];
    int unsigned pc2;
    int unsigned qp, ti, tt;
    rst_n = 1'b0; ghu = 1'b0; ghr = '0; pc = '0;
    uvalid = 1'b0; uidx = '0; uway = '0; utag = '0; uctr = '0; uuse = '0;
    u_ctr = 1'b0; i_ctr = 1'b0; u_use = 1'b0; i_use = 1'b0; realloc = 1'b0;
    m_ghr = 0;
`ifdef TAGGED_USEFUL_DECAY_EN
    d_rst_n = 1'b0; d_uvalid = 1'b0; d_pc = '0; d_uidx = '0; d_uway = '0; d_utag = '0; d_uuse = '0;
`endif
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < DEPTH; s++) begin
        m_tag[w][s] = 0; m_ctr[w][s] = 0; m_use[w][s] = 0;
      end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_hit", hit, 0);
    checkOutput("rst_qtag", qtag, 0);
    uvalid = 1'b1; #1;
    checkOutput("rst_drop", drop, 0);
    uvalid = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Mid-INIT behaviour, then a reset that must restart the sweep
    repeat (100) @(posedge clk);
    #1;
    checkOutput("init_ready", ready, 0);
    pc = 32'h2248C; uvalid = 1'b1; #1;
    checkOutput("init_drop", drop, 1);
    @(posedge clk); #1;
    uvalid = 1'b0;
    checkOutput("init_hit", hit, 0);
    @(negedge clk); rst_n = 1'b0; #2; rst_n = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("init_len", n, DEPTH);

    // Fresh allocation in way 1, set 5, tag 0x123
    pc2 = 32'h2248C;
    applyStimulus(1, 5, 1, 'h123, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    check_query();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, pc2, 0, 0);
    check_query();
    checkOutput("t2_index", qidx, 5);
    checkOutput("t2_tag", qtag, 'h123);
    checkOutput("t2_hit", hit, 1);
    checkOutput("t2_way", hway, 1);
    checkOutput("t2_ctr", ctr, 4);
    checkOutput("t2_taken", taken, 1);

    // Saturation at both ends, observed through the same-cycle bypass
    applyStimulus(1, 5, 1, 'h123, 7, 3, 1, 1, 1, 1, 0, pc2, 0, 0);
    check_query();
    checkOutput("t3_ctr_max", ctr, 7);
    checkOutput("t3_use_max", useful_b, 3);
    applyStimulus(1, 5, 1, 'h123, 0, 0, 1, 0, 1, 0, 0, pc2, 0, 0);
    check_query();
    checkOutput("t3_ctr_min", ctr, 0);
    checkOutput("t3_use_min", useful_b, 0);
    applyStimulus(1, 5, 1, 'h123, 5, 2, 1, 1, 0, 0, 0, pc2, 0, 0);
    check_query();
    checkOutput("t4_bypass_ctr", ctr, 6);
    checkOutput("t4_bypass_use", useful_b, 2);

    // Allocation candidate
    applyStimulus(1, 5, 0, 'h7, 1, 2, 0, 0, 0, 0, 0, pc2, 0, 0);
    check_query();
    checkOutput("t5_alloc_none", aval, 0);
    applyStimulus(1, 5, 0, 'h7, 1, 0, 0, 0, 0, 0, 0, pc2, 0, 0);
    check_query();
    checkOutput("t5_alloc_valid", aval, 1);
    checkOutput("t5_alloc_way", away, 0);

    // Random traffic against the table model
    for (int i = 0; i < 8; i++) pool[i] = $urandom;
    for (int c = 0; c < 3000; c++) begin
      qp = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 0) begin
        tt = pool[$urandom_range(0, 7)];
        ti = idx_of(tt, m_ghr, 10);
        tt = tag_of(tt, m_ghr);
      end else begin
        ti = $urandom_range(0, DEPTH - 1);
        tt = $urandom_range(0, 2047);
      end
      applyStimulus($urandom_range(0, 9) < 6, ti, $urandom_range(0, 1), tt,
                    $urandom_range(0, 7), $urandom_range(0, 3),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 3) == 0, qp,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 31));
      check_query();
    end

`ifdef TAGGED_USEFUL_DECAY_EN
    // Useful aging on a small table
    @(negedge clk); d_rst_n = 1'b1;
    n = 0;
    while (d_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("t6_init", n, 8);
    d_pc = 32'h1234; d_uvalid = 1'b1; d_uway = 1'b1; d_uuse = 2'd3;
    d_uidx = 3'(idx_of(32'h1234, 0, 3)); d_utag = 11'(tag_of(32'h1234, 0));
    @(posedge clk); #1;
    d_uvalid = 1'b0;
    n = 0;
    while (d_ready === 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("t6_enter", d_ready, 0);
    d_uvalid = 1'b1; d_uuse = 2'd2; #1;
    checkOutput("t6_drop", d_drop, 1);
    @(posedge clk); #1;
    d_uvalid = 1'b0;
    checkOutput("t6_hit_decay", d_hit, 0);
    n = 0;
    while (d_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("t6_len", n + 1, 9);
    @(posedge clk); #1;
    checkOutput("t6_hit", d_hit, 1);
    checkOutput("t6_way", d_hway, 1);
    checkOutput("t6_useful", d_useful, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
